pic_ctrl_core: RTL and testbench
================================

Name: pic_ctrl_core

Overview:
- Control core of an 8259A-style programmable interrupt controller (8086 mode).
- Merges three functions: data-bus buffer, ICW/OCW control sequencer with INT/INTA handshake, and cascade buffer.
- Sits between the read/write decode logic and the IRR/IMR/ISR/priority-resolver datapath.
- Owns IMR, the vector base, mode bits and the slave ID.

Parameters:
- none (all widths fixed at 8 IR lines, 3-bit level codes)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_pulse  in  1  one-cycle write strobe (CS and WR already qualified)
- rd_en  in  1  read active (CS and RD already qualified)
- a0  in  1  register address bit
- d_in  in  8  CPU data in
- d_out  out  8  CPU data out
- d_oe  out  1  d_out valid/drive enable
- inta  in  1  active-high interrupt acknowledge from CPU (asynchronous level)
- sp_en  in  1  1 = master, 0 = slave
- cas_in  in  3  cascade address from master (slave use)
- cas_out  out  3  cascade address driven by master
- cas_oe  out  1  cas_out drive enable
- irr  in  8  request register
- isr  in  8  in-service register
- req_valid  in  1  resolver: unmasked request outranks in-service
- req_level  in  3  resolver: highest-priority pending level
- isr_top  in  3  highest-priority in-service level
- imr  out  8  interrupt mask register
- ltim  out  1  1 = level triggered, 0 = edge triggered
- int_o  out  1  interrupt request to CPU
- isr_set  out  1  one-cycle pulse: set ISR[req_level], freeze IRR
- isr_clr  out  1  one-cycle pulse: clear ISR[clr_level]
- clr_level  out  3  level to clear
- init_clr  out  1  one-cycle pulse on ICW1: clear ISR/IRR edge state
- prio_wr  out  1  one-cycle pulse: lowest-priority level = prio_level
- prio_level  out  3  new lowest-priority level

Behaviour:
- Reset: state=WAIT_ICW1; imr=0x00; ltim=0; vector base=0; sngl=1; ic4=0; aeoi=0; id=0; slave mask=0; read-select=IRR. Outputs int_o, d_oe, cas_oe and all pulses 0; d_out=0; cas_out=0.
- Write decode: a0=0 with d_in[4]=1 is ICW1 in any state and restarts the sequence.
  - ICW1 latches ltim=d[3], sngl=d[1], ic4=d[0]; clears imr and aeoi; pulses init_clr; goes to WAIT_ICW2.
- WAIT_ICW2: a0=1 write latches base=d[7:3].
  - Next state WAIT_ICW3 if sngl=0, else WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW3: a0=1 write.
  - Master (sp_en=1): slave mask=d.
  - Slave: id=d[2:0].
  - Next state WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4: a0=1 write latches aeoi=d[1], then READY.
- READY writes:
  - a0=1 is OCW1: imr=d.
  - a0=0 with d[4:3]=00 is OCW2, decoded on d[7:5]:
    - 001 non-specific EOI: isr_clr at isr_top.
    - 011 specific EOI: isr_clr at d[2:0].
    - 101: as 001 plus prio_wr(isr_top).
    - 111: as 011 plus prio_wr(d[2:0]).
    - 110: prio_wr(d[2:0]) only.
    - Other codes: no action.
  - a0=0 with d[4:3]=01 is OCW3: if d[1]=1, read-select=ISR when d[0]=1, else IRR.
- Reads: rd_en drives d_oe=1 the same cycle (combinational).
  - d_out=imr when a0=1, else the selected IRR/ISR.
  - In any init state other than READY, a0=0 reads return irr.
- INTA handling: inta is synchronised by 2 flops; rising/falling edges detected on the synchronised value. INTA cycle has priority over rd_en on d_out.
- int_o is registered: 1 when state=READY, req_valid=1 and no INTA sequence is in progress.
- 1st INTA rising edge:
  - Pulse isr_set and capture level L=req_level.
  - Drop int_o.
  - Master with sngl=0 and slave mask[L]=1: cas_out=L and cas_oe=1 until the 2nd INTA falls.
- 2nd INTA rising edge: d_oe=1, d_out={base,L}, held while inta=1. Vector drive is enabled only when one of these holds:
  - sngl=1;
  - master with slave mask[L]=0;
  - slave with cas_in=id (slave uses its own req_level).
- 2nd INTA falling edge: if aeoi=1, pulse isr_clr with clr_level=L. Sequence ends.
- INTA while not READY, or while req_valid=0 at the 1st edge, is ignored (no pulses).
- ICW1 or rst mid-sequence aborts the INTA sequence and deasserts d_oe, cas_oe and int_o.
- Simultaneous wr_pulse and INTA edge: both are processed in the same cycle.

Decomposition:
- Package pic_pkg holds:
  - state enum {WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY};
  - INTA phase enum {IDLE, ACK1, ACK2};
  - OCW2 code constants;
  - bit-index constants for ICW1 and ICW4 fields.
- One sub-module pic_cascade_buf: inputs sp_en, sngl, slave mask, id, L, cas_in, phase; outputs cas_out, cas_oe, vector enable.

Test Plan:
- Single, AEOI, level: ICW1 0x1B, ICW2 0xA8, ICW4 0x02, OCW1 0x80; req_level=3, req_valid=1 gives int_o=1. INTA pulse 1 gives isr_set with no cas_oe. INTA pulse 2 gives d_out=0xAB; the falling edge pulses isr_clr with clr_level=3.
- Slave: sp_en=0; ICW1 0x19, ICW2 0xA9, ICW3 0x02, ICW4 0x02; cas_in=2, level 2. 2nd INTA gives d_out=0xAA and cas_oe=0. The same run with cas_in=5 gives d_oe=0 on the 2nd INTA.
- Master cascade: sp_en=1; ICW3 0x08, level 3. cas_out=3 and cas_oe=1 from ACK1 until the 2nd INTA falls; d_oe=0 on ACK2.
- OCW2 non-AEOI: 0x20 with isr_top=5 gives isr_clr at level 5. 0x63 gives isr_clr at level 3. 0xE4 gives isr_clr at level 4 plus prio_wr at level 4.
- Reads: OCW3 0x0B, then a0=0 read gives isr. OCW3 0x0A gives irr. a0=1 read gives imr=0x80.
- Reset/abort: ICW1 written between the two INTA pulses gives int_o=0, no vector, state=WAIT_ICW2, imr=0x00.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style interrupt controller core.
package pic_pkg;

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_e;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    ACK2
  } phase_e;

  // OCW2 R/SL/EOI codes (d[7:5])
  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;
  localparam logic [2:0] OCW2_SET_PRIO   = 3'b110;

  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_LTIM = 3;
  localparam int unsigned ICW1_SEL  = 4;
  localparam int unsigned ICW4_AEOI = 1;

endpackage

// File: rtl/pic_ctrl_core_if.sv
// CPU-side bus of the interrupt controller: register access plus the INT/INTA handshake.
interface pic_ctrl_core_if;
  logic       wr_pulse;
  logic       rd_en;
  logic       a0;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       inta;
  logic       int_o;

  modport master (
    output wr_pulse, rd_en, a0, d_in, inta,
    input  d_out, d_oe, int_o
  );

  modport slave (
    input  wr_pulse, rd_en, a0, d_in, inta,
    output d_out, d_oe, int_o
  );
endinterface

// File: rtl/pic_cascade_buf.sv
// Cascade buffer: drives the cascade address as master and decides who supplies the vector.
module pic_cascade_buf
  import pic_pkg::*;
(
  input  logic       sp_en,
  input  logic       sngl,
  input  logic [7:0] slave_mask,
  input  logic [2:0] id,
  input  logic [2:0] lvl,
  input  logic [2:0] cas_in,
  input  phase_e     phase,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       vec_en
);

  logic cascaded;

  always_comb begin
    cascaded = sp_en & ~sngl & slave_mask[lvl];
    cas_oe   = cascaded & (phase != IDLE);
    cas_out  = cas_oe ? lvl : 3'd0;
    // A master defers the vector to the slave it addressed on the cascade lines.
    vec_en   = (phase == ACK2) &
               (sngl | (sp_en & ~slave_mask[lvl]) | (~sp_en & (cas_in == id)));
  end

endmodule

// File: rtl/pic_ctrl_core.sv
// 8259A-style control core: ICW/OCW sequencer, INTA handshake, data-bus and cascade buffers.
module pic_ctrl_core
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  pic_ctrl_core_if.slave bus,
  input  logic       sp_en,
  input  logic [2:0] cas_in,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  input  logic       req_valid,
  input  logic [2:0] req_level,
  input  logic [2:0] isr_top,
  output logic [7:0] imr,
  output logic       ltim,
  output logic       isr_set,
  output logic       isr_clr,
  output logic [2:0] clr_level,
  output logic       init_clr,
  output logic       prio_wr,
  output logic [2:0] prio_level
);

  state_e     state;
  phase_e     phase;
  logic [4:0] base;
  logic       sngl, ic4, aeoi, rsel;
  logic [7:0] slave_mask;
  logic [2:0] id, lvl;
  logic       inta_s1, inta_s2, inta_s3;
  logic       inta_rise, inta_fall, icw1_wr, ack_start, vec_en;

  assign inta_rise = inta_s2 & ~inta_s3;
  assign inta_fall = ~inta_s2 & inta_s3;
  assign icw1_wr   = bus.wr_pulse & ~bus.a0 & bus.d_in[ICW1_SEL];
  assign ack_start = inta_rise & (phase == IDLE) & (state == READY) & req_valid;

  pic_cascade_buf u_cascade_buf (
    .sp_en      (sp_en),
    .sngl       (sngl),
    .slave_mask (slave_mask),
    .id         (id),
    .lvl        (lvl),
    .cas_in     (cas_in),
    .phase      (phase),
    .cas_out    (cas_out),
    .cas_oe     (cas_oe),
    .vec_en     (vec_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_ICW1;
      phase      <= IDLE;
      imr        <= 8'h00;
      ltim       <= 1'b0;
      base       <= 5'd0;
      sngl       <= 1'b1;
      ic4        <= 1'b0;
      aeoi       <= 1'b0;
      rsel       <= 1'b0;
      slave_mask <= 8'h00;
      id         <= 3'd0;
      lvl        <= 3'd0;
      inta_s1    <= 1'b0;
      inta_s2    <= 1'b0;
      inta_s3    <= 1'b0;
      bus.int_o  <= 1'b0;
      isr_set    <= 1'b0;
      isr_clr    <= 1'b0;
      clr_level  <= 3'd0;
      init_clr   <= 1'b0;
      prio_wr    <= 1'b0;
      prio_level <= 3'd0;
    end else begin
      inta_s1   <= bus.inta;
      inta_s2   <= inta_s1;
      inta_s3   <= inta_s2;
      isr_set   <= 1'b0;
      isr_clr   <= 1'b0;
      init_clr  <= 1'b0;
      prio_wr   <= 1'b0;
      bus.int_o <= (state == READY) & req_valid & (phase == IDLE) & ~ack_start & ~icw1_wr;

      case (phase)
        IDLE: begin
          if (ack_start) begin
            phase   <= ACK1;
            lvl     <= req_level;
            isr_set <= 1'b1;
          end
        end
        ACK1: if (inta_rise) phase <= ACK2;
        ACK2: begin
          if (inta_fall) begin
            phase <= IDLE;
            if (aeoi) begin
              isr_clr   <= 1'b1;
              clr_level <= lvl;
            end
          end
        end
        default: phase <= IDLE;
      endcase

      // ICW1 is assigned last so it overrides any INTA progress in the same cycle.
      if (icw1_wr) begin
        ltim     <= bus.d_in[ICW1_LTIM];
        sngl     <= bus.d_in[ICW1_SNGL];
        ic4      <= bus.d_in[ICW1_IC4];
        imr      <= 8'h00;
        aeoi     <= 1'b0;
        init_clr <= 1'b1;
        phase    <= IDLE;
        state    <= WAIT_ICW2;
      end else if (bus.wr_pulse) begin
        case (state)
          WAIT_ICW2: begin
            if (bus.a0) begin
              base <= bus.d_in[7:3];
              if (!sngl)    state <= WAIT_ICW3;
              else if (ic4) state <= WAIT_ICW4;
              else          state <= READY;
            end
          end
          WAIT_ICW3: begin
            if (bus.a0) begin
              if (sp_en) slave_mask <= bus.d_in;
              else       id         <= bus.d_in[2:0];
              state <= ic4 ? WAIT_ICW4 : READY;
            end
          end
          WAIT_ICW4: begin
            if (bus.a0) begin
              aeoi  <= bus.d_in[ICW4_AEOI];
              state <= READY;
            end
          end
          READY: begin
            if (bus.a0) begin
              imr <= bus.d_in;
            end else if (bus.d_in[4:3] == 2'b00) begin
              case (bus.d_in[7:5])
                OCW2_NS_EOI: begin
                  isr_clr   <= 1'b1;
                  clr_level <= isr_top;
                end
                OCW2_SP_EOI: begin
                  isr_clr   <= 1'b1;
                  clr_level <= bus.d_in[2:0];
                end
                OCW2_ROT_NS_EOI: begin
                  isr_clr    <= 1'b1;
                  clr_level  <= isr_top;
                  prio_wr    <= 1'b1;
                  prio_level <= isr_top;
                end
                OCW2_ROT_SP_EOI: begin
                  isr_clr    <= 1'b1;
                  clr_level  <= bus.d_in[2:0];
                  prio_wr    <= 1'b1;
                  prio_level <= bus.d_in[2:0];
                end
                OCW2_SET_PRIO: begin
                  prio_wr    <= 1'b1;
                  prio_level <= bus.d_in[2:0];
                end
                default: ;
              endcase
            end else if ((bus.d_in[4:3] == 2'b01) && bus.d_in[1]) begin
              rsel <= bus.d_in[0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The acknowledge vector takes the data bus ahead of any register read.
  always_comb begin
    bus.d_oe  = 1'b0;
    bus.d_out = 8'h00;
    if (vec_en) begin
      bus.d_oe  = 1'b1;
      bus.d_out = {base, lvl};
    end else if (bus.rd_en) begin
      bus.d_oe = 1'b1;
      if (bus.a0)                         bus.d_out = imr;
      else if ((state == READY) && rsel)  bus.d_out = isr;
      else                                bus.d_out = irr;
    end
  end

endmodule

// File: tb/tb_pic_ctrl_core.sv
// Directed bench for pic_ctrl_core: register table plus hand-written INTA sequences.
module tb_pic_ctrl_core;
  import pic_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pic_ctrl_core_if bus ();

  logic       sp_en, cas_oe, req_valid, ltim, isr_set, isr_clr, init_clr, prio_wr;
  logic [2:0] cas_in, cas_out, req_level, isr_top, clr_level, prio_level;
  logic [7:0] irr, isr, imr;

  pic_ctrl_core dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sp_en      (sp_en),
    .cas_in     (cas_in),
    .cas_out    (cas_out),
    .cas_oe     (cas_oe),
    .irr        (irr),
    .isr        (isr),
    .req_valid  (req_valid),
    .req_level  (req_level),
    .isr_top    (isr_top),
    .imr        (imr),
    .ltim       (ltim),
    .isr_set    (isr_set),
    .isr_clr    (isr_clr),
    .clr_level  (clr_level),
    .init_clr   (init_clr),
    .prio_wr    (prio_wr),
    .prio_level (prio_level)
  );

  int nvec  = 0;
  int nfail = 0;
  int n_set = 0;
  int n_clr = 0;
  logic [2:0] last_clr = 3'd0;

  always @(negedge clk) begin
    if (isr_set) n_set <= n_set + 1;
    if (isr_clr) begin
      n_clr    <= n_clr + 1;
      last_clr <= clr_level;
    end
  end

  typedef struct {
    logic       is_rd;
    logic       a0;
    logic [7:0] d;
    logic [2:0] top;
    logic [7:0] exp_data;   // imr after a write, d_out for a read
    logic [2:0] exp_pulse;  // {init_clr, isr_clr, prio_wr}
    logic [2:0] exp_clr;
    logic [2:0] exp_prio;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.a0       = a;
    bus.d_in     = d;
    bus.wr_pulse = 1'b1;
    cyc(1);
    bus.wr_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic set_inta(input logic v);
    bus.inta = v;
    cyc(4);
  endtask

  int set0, clr0;

  initial begin
    rst          = 1'b1;
    bus.wr_pulse = 1'b0;
    bus.rd_en    = 1'b0;
    bus.a0       = 1'b0;
    bus.d_in     = 8'h00;
    bus.inta     = 1'b0;
    sp_en        = 1'b1;
    cas_in       = 3'd0;
    irr          = 8'h5A;
    isr          = 8'h24;
    req_valid    = 1'b0;
    req_level    = 3'd0;
    isr_top      = 3'd0;

    tv[0]  = '{1'b0, 1'b0, 8'h1B, 3'd0, 8'h00, 3'b100, 3'd0, 3'd0};
    tv[1]  = '{1'b0, 1'b1, 8'hA8, 3'd0, 8'h00, 3'b000, 3'd0, 3'd0};
    tv[2]  = '{1'b1, 1'b0, 8'h00, 3'd0, 8'h5A, 3'b000, 3'd0, 3'd0};
    tv[3]  = '{1'b0, 1'b1, 8'h02, 3'd0, 8'h00, 3'b000, 3'd0, 3'd0};
    tv[4]  = '{1'b0, 1'b1, 8'h80, 3'd0, 8'h80, 3'b000, 3'd0, 3'd0};
    tv[5]  = '{1'b1, 1'b1, 8'h00, 3'd0, 8'h80, 3'b000, 3'd0, 3'd0};
    tv[6]  = '{1'b0, 1'b0, 8'h0B, 3'd0, 8'h80, 3'b000, 3'd0, 3'd0};
    tv[7]  = '{1'b1, 1'b0, 8'h00, 3'd0, 8'h24, 3'b000, 3'd0, 3'd0};
    tv[8]  = '{1'b0, 1'b0, 8'h0A, 3'd0, 8'h80, 3'b000, 3'd0, 3'd0};
    tv[9]  = '{1'b1, 1'b0, 8'h00, 3'd0, 8'h5A, 3'b000, 3'd0, 3'd0};
    tv[10] = '{1'b0, 1'b0, 8'h20, 3'd5, 8'h80, 3'b010, 3'd5, 3'd0};
    tv[11] = '{1'b0, 1'b0, 8'h63, 3'd5, 8'h80, 3'b010, 3'd3, 3'd0};
    tv[12] = '{1'b0, 1'b0, 8'hE4, 3'd5, 8'h80, 3'b011, 3'd4, 3'd4};
    tv[13] = '{1'b0, 1'b0, 8'hA0, 3'd6, 8'h80, 3'b011, 3'd6, 3'd6};
    tv[14] = '{1'b0, 1'b0, 8'hC2, 3'd6, 8'h80, 3'b001, 3'd0, 3'd2};
    tv[15] = '{1'b0, 1'b0, 8'h40, 3'd6, 8'h80, 3'b000, 3'd0, 3'd0};
    tv[16] = '{1'b0, 1'b0, 8'h0B, 3'd0, 8'h80, 3'b000, 3'd0, 3'd0};
    tv[17] = '{1'b0, 1'b0, 8'h08, 3'd0, 8'h80, 3'b000, 3'd0, 3'd0};
    tv[18] = '{1'b1, 1'b0, 8'h00, 3'd0, 8'h24, 3'b000, 3'd0, 3'd0};

    // Reset state
    do_reset();
    chk("rst_int_o", {7'd0, bus.int_o}, 8'h00);
    chk("rst_d_oe", {7'd0, bus.d_oe}, 8'h00);
    chk("rst_d_out", bus.d_out, 8'h00);
    chk("rst_cas", {4'd0, cas_oe, cas_out}, 8'h00);
    chk("rst_imr_ltim", {imr[6:0], ltim}, 8'h00);
    chk("rst_pulses", {4'd0, isr_set, isr_clr, init_clr, prio_wr}, 8'h00);

    // Register programming, OCW2/OCW3 decode and reads
    for (int i = 0; i < 19; i++) begin
      isr_top = tv[i].top;
      if (tv[i].is_rd) begin
        bus.a0    = tv[i].a0;
        bus.rd_en = 1'b1;
        #1;
        chk($sformatf("rd_data[%0d]", i), bus.d_out, tv[i].exp_data);
        chk($sformatf("rd_oe[%0d]", i), {7'd0, bus.d_oe}, 8'h01);
        bus.rd_en = 1'b0;
        cyc(1);
      end else begin
        wr(tv[i].a0, tv[i].d);
        chk($sformatf("pulses[%0d]", i), {5'd0, init_clr, isr_clr, prio_wr},
            {5'd0, tv[i].exp_pulse});
        chk($sformatf("imr[%0d]", i), imr, tv[i].exp_data);
        if (tv[i].exp_pulse[1])
          chk($sformatf("clr_level[%0d]", i), {5'd0, clr_level}, {5'd0, tv[i].exp_clr});
        if (tv[i].exp_pulse[0])
          chk($sformatf("prio_level[%0d]", i), {5'd0, prio_level}, {5'd0, tv[i].exp_prio});
      end
    end
    chk("ltim", {7'd0, ltim}, 8'h01);

    // Single mode with AEOI: full INTA sequence at level 3
    req_level = 3'd3;
    req_valid = 1'b1;
    cyc(2);
    chk("a_int_o", {7'd0, bus.int_o}, 8'h01);
    set0 = n_set;
    clr0 = n_clr;
    set_inta(1'b1);
    chk("a_isr_set", 8'(n_set - set0), 8'd1);
    chk("a_int_drop", {7'd0, bus.int_o}, 8'h00);
    chk("a_cas_oe", {7'd0, cas_oe}, 8'h00);
    set_inta(1'b0);
    set_inta(1'b1);
    chk("a_vec_oe", {7'd0, bus.d_oe}, 8'h01);
    chk("a_vec", bus.d_out, 8'hAB);
    set_inta(1'b0);
    chk("a_aeoi_clr", 8'(n_clr - clr0), 8'd1);
    chk("a_aeoi_lvl", {5'd0, last_clr}, 8'd3);
    chk("a_vec_off", {7'd0, bus.d_oe}, 8'h00);

    // Slave, addressed and not addressed
    req_valid = 1'b0;
    sp_en     = 1'b0;
    do_reset();
    wr(1'b0, 8'h19);
    wr(1'b1, 8'hA9);
    wr(1'b1, 8'h02);
    wr(1'b1, 8'h02);
    cas_in    = 3'd2;
    req_level = 3'd2;
    req_valid = 1'b1;
    cyc(2);
    set_inta(1'b1);
    set_inta(1'b0);
    set_inta(1'b1);
    chk("b_vec_oe", {7'd0, bus.d_oe}, 8'h01);
    chk("b_vec", bus.d_out, 8'hAA);
    chk("b_cas_oe", {7'd0, cas_oe}, 8'h00);
    set_inta(1'b0);
    cas_in = 3'd5;
    set0   = n_set;
    set_inta(1'b1);
    chk("b2_isr_set", 8'(n_set - set0), 8'd1);
    set_inta(1'b0);
    set_inta(1'b1);
    chk("b2_no_vec", {7'd0, bus.d_oe}, 8'h00);
    set_inta(1'b0);

    // Master with a slave on IR3, no AEOI
    req_valid = 1'b0;
    sp_en     = 1'b1;
    do_reset();
    wr(1'b0, 8'h19);
    wr(1'b1, 8'hA8);
    wr(1'b1, 8'h08);
    wr(1'b1, 8'h00);
    req_level = 3'd3;
    req_valid = 1'b1;
    cyc(2);
    clr0 = n_clr;
    set_inta(1'b1);
    chk("c_cas_ack1", {4'd0, cas_oe, cas_out}, 8'h0B);
    set_inta(1'b0);
    chk("c_cas_gap", {4'd0, cas_oe, cas_out}, 8'h0B);
    set_inta(1'b1);
    chk("c_cas_ack2", {4'd0, cas_oe, cas_out}, 8'h0B);
    chk("c_no_vec", {7'd0, bus.d_oe}, 8'h00);
    set_inta(1'b0);
    chk("c_cas_end", {4'd0, cas_oe, cas_out}, 8'h00);
    chk("c_no_aeoi", 8'(n_clr - clr0), 8'd0);

    // ICW1 between the two INTA pulses aborts the sequence
    req_valid = 1'b0;
    do_reset();
    wr(1'b0, 8'h1B);
    wr(1'b1, 8'hA8);
    wr(1'b1, 8'h02);
    wr(1'b1, 8'h80);
    req_level = 3'd3;
    req_valid = 1'b1;
    cyc(2);
    set_inta(1'b1);
    set_inta(1'b0);
    wr(1'b0, 8'h13);
    chk("d_init_clr", {7'd0, init_clr}, 8'h01);
    cyc(1);
    chk("d_int_o", {7'd0, bus.int_o}, 8'h00);
    chk("d_state", 8'(dut.state), 8'(WAIT_ICW2));
    chk("d_imr", imr, 8'h00);
    set0 = n_set;
    set_inta(1'b1);
    chk("d_no_vec", {7'd0, bus.d_oe}, 8'h00);
    chk("d_no_set", 8'(n_set - set0), 8'd0);
    set_inta(1'b0);
    chk("d_int_stays", {7'd0, bus.int_o}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
